// File: rtl/move_ctrl.sv
// Move controller: cursor, drop request handshake and per-column fill tracking.
// Optional MOVE_CTRL_SKIP_FULL_EN makes the cursor skip over full columns.
module move_ctrl #(
    parameter int unsigned COLS = 7,
    parameter int unsigned ROWS = 6,
    parameter int unsigned WRAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            left_pulse,
    input  logic            right_pulse,
    input  logic            drop_pulse,
    input  logic            new_game,
    input  logic            game_active,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [2:0]      wr_col,
    output logic [2:0]      wr_row,
    output logic            wr_player,
    output logic [2:0]      col_sel,
    output logic            player,
    output logic [COLS-1:0] col_full,
    output logic            board_full,
    output logic [5:0]      move_count,
    output logic            drop_err
);

    localparam logic [2:0] LastCol = 3'(COLS - 1);
    localparam logic [2:0] HomeCol = 3'(COLS / 2);
    localparam logic [2:0] FullH   = 3'(ROWS);
    localparam logic [5:0] Cells   = 6'(COLS * ROWS);

    typedef enum logic [1:0] {StSelect, StIssue, StCommit, StDone} state_e;

    state_e     state_q;
    logic [2:0] height_q [COLS];
    logic [2:0] left_tgt;
    logic [2:0] right_tgt;
    logic [2:0] commit_tgt;

    function automatic logic [2:0] step_col(input logic [2:0] c, input logic right,
                                            input logic wrap);
        if (right) begin
            if (c == LastCol) return wrap ? 3'd0 : c;
            return c + 3'd1;
        end
        if (c == 3'd0) return wrap ? LastCol : c;
        return c - 3'd1;
    endfunction

    always_comb begin
        col_full = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            col_full[c] = (height_q[c] == FullH);
        end
    end

`ifdef MOVE_CTRL_SKIP_FULL_EN
    logic [COLS-1:0] full_next;

    // Nearest non-full column in the given direction; holds when none exists.
    function automatic logic [2:0] seek_col(input logic [2:0] c, input logic right,
                                            input logic wrap, input logic [COLS-1:0] full);
        logic [2:0] cand;
        logic [2:0] res;
        logic       found;
        cand  = c;
        res   = c;
        found = 1'b0;
        for (int i = 1; i < int'(COLS); i++) begin
            cand = step_col(cand, right, wrap);
            if (!found && cand != c && !full[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        full_next = col_full;
        if (height_q[wr_col] + 3'd1 == FullH) full_next[wr_col] = 1'b1;
    end

    assign left_tgt   = seek_col(col_sel, 1'b0, WRAP != 0, col_full);
    assign right_tgt  = seek_col(col_sel, 1'b1, WRAP != 0, col_full);
    assign commit_tgt = full_next[col_sel] ? seek_col(col_sel, 1'b1, 1'b1, full_next) : col_sel;
`else
    assign left_tgt   = step_col(col_sel, 1'b0, WRAP != 0);
    assign right_tgt  = step_col(col_sel, 1'b1, WRAP != 0);
    assign commit_tgt = col_sel;
`endif

    assign board_full = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state_q    <= StSelect;
            col_sel    <= HomeCol;
            player     <= 1'b0;
            move_count <= '0;
            wr_valid   <= 1'b0;
            wr_col     <= '0;
            wr_row     <= '0;
            wr_player  <= 1'b0;
            drop_err   <= 1'b0;
            for (int c = 0; c < int'(COLS); c++) begin
                height_q[c] <= '0;
            end
        end else begin
            drop_err <= 1'b0;
            case (state_q)
                StSelect: begin
                    if (game_active) begin
                        // Drop wins over any simultaneous cursor move.
                        if (drop_pulse) begin
                            if (col_full[col_sel]) begin
                                drop_err <= 1'b1;
                            end else begin
                                wr_col    <= col_sel;
                                wr_row    <= height_q[col_sel];
                                wr_player <= player;
                                wr_valid  <= 1'b1;
                                state_q   <= StIssue;
                            end
                        end else if (left_pulse && !right_pulse) begin
                            col_sel <= left_tgt;
                        end else if (right_pulse && !left_pulse) begin
                            col_sel <= right_tgt;
                        end
                    end
                end
                StIssue: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        state_q  <= StCommit;
                    end
                end
                StCommit: begin
                    if (height_q[wr_col] != FullH) height_q[wr_col] <= height_q[wr_col] + 3'd1;
                    if (move_count != Cells) move_count <= move_count + 6'd1;
                    player  <= ~player;
                    col_sel <= commit_tgt;
                    state_q <= (move_count + 6'd1 >= Cells) ? StDone : StSelect;
                end
                StDone: ;
                default: state_q <= StSelect;
            endcase
        end
    end

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl at default parameters (7x6 board, wrapping cursor).
module tb_move_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       left_pulse, right_pulse, drop_pulse;
    logic       new_game, game_active;
    logic       wr_valid, wr_ready;
    logic [2:0] wr_col, wr_row;
    logic       wr_player;
    logic [2:0] col_sel;
    logic       player;
    logic [6:0] col_full;
    logic       board_full;
    logic [5:0] move_count;
    logic       drop_err;

    int total = 0;
    int bad   = 0;
    int n;

    move_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse),
        .drop_pulse (drop_pulse),
        .new_game   (new_game),
        .game_active(game_active),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_player  (wr_player),
        .col_sel    (col_sel),
        .player     (player),
        .col_full   (col_full),
        .board_full (board_full),
        .move_count (move_count),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic l, input logic r, input logic d);
        left_pulse  = l;
        right_pulse = r;
        drop_pulse  = d;
        tick();
        left_pulse  = 1'b0;
        right_pulse = 1'b0;
        drop_pulse  = 1'b0;
    endtask

    task automatic clear_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // Drop with wr_ready held high: ISSUE, COMMIT, then back in SELECT/DONE.
    task automatic drop_commit(input int exp_col, input int exp_row, input int exp_player);
        drop_pulse = 1'b1;
        wr_ready   = 1'b1;
        tick();
        drop_pulse = 1'b0;
        check("issue_valid", 32'(wr_valid), 1);
        check("issue_col", 32'(wr_col), exp_col);
        check("issue_row", 32'(wr_row), exp_row);
        check("issue_player", 32'(wr_player), exp_player);
        tick();
        tick();
        wr_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        left_pulse = 1'b0; right_pulse = 1'b0; drop_pulse = 1'b0;
        new_game = 1'b0; game_active = 1'b1; wr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_col_sel", 32'(col_sel), 3);
        check("rst_player", 32'(player), 0);
        check("rst_move_count", 32'(move_count), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_col_full", 32'(col_full), 0);
        check("rst_board_full", 32'(board_full), 0);
        check("rst_drop_err", 32'(drop_err), 0);

        // Cursor stepping and wrap
        pulse(0, 1, 0); check("right1", 32'(col_sel), 4);
        pulse(0, 1, 0); check("right2", 32'(col_sel), 5);
        pulse(0, 1, 0); check("right3", 32'(col_sel), 6);
        pulse(1, 0, 0); check("left1", 32'(col_sel), 5);
        pulse(0, 1, 0); check("right4", 32'(col_sel), 6);
        pulse(0, 1, 0); check("wrap_right", 32'(col_sel), 0);
        pulse(1, 0, 0); check("wrap_left", 32'(col_sel), 6);
        game_active = 1'b0;
        pulse(1, 0, 0); check("inactive_left", 32'(col_sel), 6);
        game_active = 1'b1;
        pulse(0, 1, 0); pulse(0, 1, 0); pulse(0, 1, 0); pulse(0, 1, 0);
        check("back_home", 32'(col_sel), 3);

        // Stalled handshake: wr_valid held 5 cycles with a stable payload
        pulse(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(wr_valid), 1);
            check("stall_col", 32'(wr_col), 3);
            check("stall_row", 32'(wr_row), 0);
            check("stall_player", 32'(wr_player), 0);
            if (i == 4) wr_ready = 1'b1;
            tick();
        end
        wr_ready = 1'b0;
        check("commit_valid_low", 32'(wr_valid), 0);
        tick();
        check("after_player", 32'(player), 1);
        check("after_count", 32'(move_count), 1);

        // Fill column 0, then drop into it again
        clear_game();
        check("ng_count", 32'(move_count), 0);
        check("ng_player", 32'(player), 0);
        pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
        check("at_col0", 32'(col_sel), 0);
        for (int r = 0; r < 6; r++) drop_commit(0, r, r % 2);
        check("col0_full", 32'(col_full), 7'b0000001);
        check("col0_cursor", 32'(col_sel), 0);
        pulse(0, 0, 1);
        check("full_drop_err", 32'(drop_err), 1);
        check("full_no_valid", 32'(wr_valid), 0);
        tick();
        check("drop_err_once", 32'(drop_err), 0);
        check("full_no_valid2", 32'(wr_valid), 0);
        check("full_count", 32'(move_count), 6);

        // Simultaneous pulses
        pulse(1, 1, 0); check("lr_same", 32'(col_sel), 0);
        pulse(0, 1, 0); check("to_col1", 32'(col_sel), 1);
        drop_pulse = 1'b1; right_pulse = 1'b1; wr_ready = 1'b1;
        tick();
        drop_pulse = 1'b0; right_pulse = 1'b0;
        check("dr_valid", 32'(wr_valid), 1);
        check("dr_col", 32'(wr_col), 1);
        check("dr_cursor", 32'(col_sel), 1);
        tick();
        tick();
        wr_ready = 1'b0;
        check("dr_count", 32'(move_count), 7);

        // Fill the whole board
        clear_game();
        pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
        n = 0;
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                if (n == 41) check("not_full_yet", 32'(board_full), 0);
                drop_commit(c, r, n % 2);
                n++;
            end
            if (c < 6) pulse(0, 1, 0);
        end
        check("done_board_full", 32'(board_full), 1);
        check("done_count", 32'(move_count), 42);
        check("done_col_full", 32'(col_full), 7'h7f);
        pulse(0, 1, 0);
        check("done_ignore_right", 32'(col_sel), 6);
        pulse(0, 0, 1);
        check("done_ignore_drop", 32'(wr_valid), 0);
        check("done_no_err", 32'(drop_err), 0);
        check("done_stays", 32'(board_full), 1);
        clear_game();
        check("ng2_col_sel", 32'(col_sel), 3);
        check("ng2_count", 32'(move_count), 0);
        check("ng2_board_full", 32'(board_full), 0);
        check("ng2_col_full", 32'(col_full), 0);

        // Reset during ISSUE
        pulse(0, 0, 1);
        check("pre_rst_valid", 32'(wr_valid), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_issue_valid", 32'(wr_valid), 0);
        check("rst_issue_count", 32'(move_count), 0);
        check("rst_issue_full", 32'(col_full), 0);
        drop_commit(3, 0, 0);
        check("post_rst_count", 32'(move_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
